// File: rtl/vga_pkg.sv
// Shared video-mode constants (SVGA 800x600@60 Hz, 40 MHz pclk) and small helpers
// used by every block in the video pipeline.
package vga_pkg;

  localparam int   VGA_H_ACTIVE = 800;
  localparam int   VGA_H_FP     = 40;
  localparam int   VGA_H_SYNC   = 128;
  localparam int   VGA_H_BP     = 88;

  localparam int   VGA_V_ACTIVE = 600;
  localparam int   VGA_V_FP     = 1;
  localparam int   VGA_V_SYNC   = 4;
  localparam int   VGA_V_BP     = 23;

  localparam logic VGA_H_POL    = 1'b1;
  localparam logic VGA_V_POL    = 1'b1;

  localparam int   VGA_CW       = 11;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int   VGA_H_TOTAL  = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int   VGA_V_TOTAL  = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter plus registered sync/blank strobes that are
// decoded from the next count so they change on the same edge as the count itself.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int   ACTIVE = VGA_H_ACTIVE,
  parameter int   FP     = VGA_H_FP,
  parameter int   SYNC   = VGA_H_SYNC,
  parameter int   BP     = VGA_H_BP,
  parameter logic POL    = 1'b1,
  parameter int   CW     = VGA_CW
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          sync,
  output logic          blnk,
  output logic          wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CW-1:0] L_LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] L_ACTIVE     = CW'(ACTIVE);
  // One extra bit so a sync window ending exactly at 2**CW still compares correctly.
  localparam logic [CW:0]   L_SYNC_START = (CW+1)'(ACTIVE + FP);
  localparam logic [CW:0]   L_SYNC_END   = (CW+1)'(ACTIVE + FP + SYNC);

  logic [CW-1:0] r_count;
  logic          r_sync;
  logic          r_blnk;

  logic [CW-1:0] w_next;
  logic          w_at_last;
  logic          w_sync_next;
  logic          w_blnk_next;

  always_comb begin
    w_at_last   = (r_count == L_LAST);
    w_next      = w_at_last ? '0 : r_count + CW'(1);
    w_sync_next = ({1'b0, w_next} >= L_SYNC_START) && ({1'b0, w_next} < L_SYNC_END);
    w_blnk_next = (w_next >= L_ACTIVE);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_sync  <= ~POL;
      r_blnk  <= 1'b0;
    end else if (step) begin
      r_count <= w_next;
      r_sync  <= w_sync_next ? POL : ~POL;
      r_blnk  <= w_blnk_next;
    end
  end

  // Combinational: tells the caller this edge takes the counter back to zero.
  assign wrap  = step & w_at_last;

  assign count = r_count;
  assign sync  = r_sync;
  assign blnk  = r_blnk;

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: horizontal/vertical counters, blanking, sync and a
// frame_start pulse, all registered and aligned to the same pclk edge.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic H_POL    = VGA_H_POL,
  parameter logic V_POL    = VGA_V_POL,
  parameter int   CW       = VGA_CW
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          frame_start
);

  logic w_h_wrap;
  logic w_v_wrap;
  logic w_v_step;
  logic r_frame_start;

  // The vertical axis only moves on the edge that ends a line.
  assign w_v_step = en & w_h_wrap;

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_POL),
    .CW     (CW)
  ) u_h_axis (
    .pclk  (pclk),
    .rst_n (rst_n),
    .step  (en),
    .count (hcount),
    .sync  (hsync),
    .blnk  (hblnk),
    .wrap  (w_h_wrap)
  );

  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_POL),
    .CW     (CW)
  ) u_v_axis (
    .pclk  (pclk),
    .rst_n (rst_n),
    .step  (w_v_step),
    .count (vcount),
    .sync  (vsync),
    .blnk  (vblnk),
    .wrap  (w_v_wrap)
  );

  // Both wraps already carry en, so a disabled edge always clears the pulse.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_h_wrap & w_v_wrap;
    end
  end

  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing using a shrunken mode (15 x 8 raster) so whole frames fit in a short run;
// a second instance with inverted sync polarity shares every stimulus.
module tb_vga_timing;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;  // 15
  localparam int VT = VA + VF + VS + VB;  // 8
  localparam int FRAME = HT * VT;         // 120
  localparam int CWT = 4;
  localparam int W = 13;
  // Vector layout: {hcount[3:0], vcount[3:0], hsync, vsync, hblnk, vblnk, frame_start}
  localparam logic [W-1:0] POL_MASK = 13'h018;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic [CWT-1:0] hcount, vcount, hcount_n, vcount_n;
  logic hsync, vsync, hblnk, vblnk, frame_start;
  logic hsync_n, vsync_n, hblnk_n, vblnk_n, frame_start_n;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int m_h = 0;
  int m_v = 0;
  logic m_fs = 1'b0;

  typedef struct {
    logic en;
    int   n;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic hb;
    logic vb;
    logic fs;
  } vec_t;

  localparam int N_TBL = 18;
  vec_t tbl[N_TBL];

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1), .CW(CWT)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .en(en),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblnk(hblnk), .vblnk(vblnk), .frame_start(frame_start)
  );

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CW(CWT)
  ) dut_n (
    .pclk(pclk), .rst_n(rst_n), .en(en),
    .hcount(hcount_n), .vcount(vcount_n), .hsync(hsync_n), .vsync(vsync_n),
    .hblnk(hblnk_n), .vblnk(vblnk_n), .frame_start(frame_start_n)
  );

  // Clock / reset
  always #5 pclk = ~pclk;

  function automatic logic [W-1:0] pack_p();
    return {hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start};
  endfunction

  function automatic logic [W-1:0] pack_n();
    return {hcount_n, vcount_n, hsync_n, vsync_n, hblnk_n, vblnk_n, frame_start_n};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference raster model
  task automatic model_reset();
    m_h = 0;
    m_v = 0;
    m_fs = 1'b0;
  endtask

  task automatic model_step(input logic e);
    m_fs = 1'b0;
    if (e) begin
      if (m_h == HT - 1) begin
        m_h = 0;
        if (m_v == VT - 1) begin
          m_v = 0;
          m_fs = 1'b1;
        end else begin
          m_v++;
        end
      end else begin
        m_h++;
      end
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic hs, vs, hb, vb;
    hs = (m_h >= HA + HF) && (m_h < HA + HF + HS);
    vs = (m_v >= VA + VF) && (m_v < VA + VF + VS);
    hb = (m_h >= HA);
    vb = (m_v >= VA);
    return {4'(m_h), 4'(m_v), hs, vs, hb, vb, m_fs};
  endfunction

  // Driver + scoreboard: push expectation when driving, pop when the DUT has produced it.
  task automatic sb_cycle(input logic e);
    logic [W-1:0] exp;
    en = e;
    model_step(e);
    exp_q.push_back(model_vec());
    @(posedge pclk);
    @(negedge pclk);
    exp = exp_q.pop_front();
    check("sb_pos", pack_p(), exp);
    check("sb_neg", pack_n(), exp ^ POL_MASK);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst_n = 1'b0;
    @(negedge pclk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [W-1:0] exp;
    int cnt;
    int k;

    //             en   n   h  v  hs vs hb vb fs
    tbl[0]  = '{1'b1,  1,  1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0,  3,  1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b1,  6,  7, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b1,  1,  8, 0, 0, 0, 1, 0, 0};
    tbl[4]  = '{1'b1,  2, 10, 0, 1, 0, 1, 0, 0};
    tbl[5]  = '{1'b1,  2, 12, 0, 1, 0, 1, 0, 0};
    tbl[6]  = '{1'b1,  1, 13, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{1'b1,  1, 14, 0, 0, 0, 1, 0, 0};
    tbl[8]  = '{1'b0,  2, 14, 0, 0, 0, 1, 0, 0};
    tbl[9]  = '{1'b1,  1,  0, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{1'b1, 45,  0, 4, 0, 0, 0, 1, 0};
    tbl[11] = '{1'b1, 15,  0, 5, 0, 1, 0, 1, 0};
    tbl[12] = '{1'b1, 14, 14, 5, 0, 1, 1, 1, 0};
    tbl[13] = '{1'b1,  1,  0, 6, 0, 1, 0, 1, 0};
    tbl[14] = '{1'b1, 15,  0, 7, 0, 0, 0, 1, 0};
    tbl[15] = '{1'b1, 14, 14, 7, 0, 0, 1, 1, 0};
    tbl[16] = '{1'b1,  1,  0, 0, 0, 0, 0, 0, 1};
    tbl[17] = '{1'b1,  1,  1, 0, 0, 0, 0, 0, 0};

    // Reset held with en=1
    rst_n = 1'b0;
    en = 1'b1;
    repeat (5) @(posedge pclk);
    @(negedge pclk);
    check("reset_pos", pack_p(), 13'h000);
    check("reset_neg", pack_n(), POL_MASK);
    rst_n = 1'b1;

    // Table-driven line/frame boundaries
    for (int i = 0; i < N_TBL; i++) begin
      en = tbl[i].en;
      repeat (tbl[i].n) @(posedge pclk);
      @(negedge pclk);
      exp = {4'(tbl[i].h), 4'(tbl[i].v), tbl[i].hs, tbl[i].vs, tbl[i].hb, tbl[i].vb, tbl[i].fs};
      check($sformatf("tbl%0d_pos", i), pack_p(), exp);
      check($sformatf("tbl%0d_neg", i), pack_n(), exp ^ POL_MASK);
    end

    // Random enable over several frames, with frame period measured in enabled edges
    do_reset();
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      logic e;
      e = ($urandom_range(0, 3) != 0);
      sb_cycle(e);
      if (e) cnt++;
      if (frame_start) begin
        check("frame_period", cnt, FRAME);
        cnt = 0;
      end
    end

    // Enable gating on the last pixel of a line
    for (k = 0; k < HT && m_h != HT - 1; k++) sb_cycle(1'b1);
    repeat (10) sb_cycle(1'b0);
    sb_cycle(1'b1);
    check("en_resume_wrap", hcount, 0);

    // Asynchronous reset in mid-frame at (5,3)
    for (k = 0; k < 2 * FRAME && !(m_h == 5 && m_v == 3); k++) sb_cycle(1'b1);
    check("midframe_pos_h", hcount, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pos", pack_p(), 13'h000);
    check("async_reset_neg", pack_n(), POL_MASK);
    @(negedge pclk);
    rst_n = 1'b1;
    model_reset();
    cnt = 0;
    for (k = 0; k < 2 * FRAME; k++) begin
      sb_cycle(1'b1);
      cnt++;
      if (frame_start) break;
    end
    check("reset_to_first_fs", cnt, FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
